// File: rtl/dat_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module : dat_mem_arbiter                                                   |
// | Two-port burst arbiter/sequencer for the 256x8 single-port data memory.    |
// | Optional: DAT_MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins).  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module dat_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [DW-1:0] wdat0,
    input  logic [DW-1:0] wdat1,
    output logic          ack0,
    output logic          ack1,
    output logic          wstb0,
    output logic          wstb1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdat0,
    output logic [DW-1:0] rdat1,
    output logic          done0,
    output logic          done1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q,    state_d;
    logic          owner_q,    owner_d;
    logic          cur_we_q,   cur_we_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW-1:0] cnt_q,      cnt_d;
    logic          ack0_q,     ack0_d;
    logic          ack1_q,     ack1_d;
    logic          rvalid0_q,  rvalid0_d;
    logic          rvalid1_q,  rvalid1_d;
    logic          done0_q,    done0_d;
    logic          done1_q,    done1_d;
    logic [DW-1:0] rdat_q,     rdat_d;
    logic          pick1;

`ifdef DAT_MEM_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    logic last_q, last_d;

    // On a tie the port that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cur_we_d   = cur_we_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdat_d     = rdat_q;
        mem_wr_en  = 1'b0;
        mem_din    = '0;
        wstb0      = 1'b0;
        wstb1      = 1'b0;
`ifndef DAT_MEM_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = pick1;
                    cur_we_d   = pick1 ? we1   : we0;
                    cur_addr_d = pick1 ? addr1 : addr0;
                    cnt_d      = pick1 ? len1  : len0;
                    ack0_d     = ~pick1;
                    ack1_d     = pick1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_wr_en = cur_we_q;
                mem_din   = owner_q ? wdat1 : wdat0;
                wstb0     = cur_we_q & ~owner_q;
                wstb1     = cur_we_q & owner_q;
                if (!cur_we_q) begin
                    rdat_d    = mem_dout;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                end
                cur_addr_d = cur_addr_q + AW'(1);
                cnt_d      = cnt_q - LW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
`ifndef DAT_MEM_ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            cur_we_q   <= 1'b0;
            cur_addr_q <= '0;
            cnt_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cur_we_q   <= cur_we_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdat_q     <= rdat_d;
        end
    end

    assign mem_addr = cur_addr_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdat0    = rdat_q;
    assign rdat1    = rdat_q;

endmodule

`default_nettype wire

// File: tb/tb_dat_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module : tb_dat_mem_arbiter                                                |
// | Scoreboard bench for dat_mem_arbiter with a behavioural memory model.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dat_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdat0 = 0, wdat1 = 0;
    logic [3:0] len0 = 0, len1 = 0;
    logic       ack0, ack1, wstb0, wstb1, rvalid0, rvalid1, done0, done1;
    logic [7:0] rdat0, rdat1, mem_addr, mem_din, mem_dout;
    logic       mem_wr_en;

    dat_mem_arbiter #(.AW(8), .DW(8), .LW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .wdat0(wdat0), .wdat1(wdat1),
        .ack0(ack0), .ack1(ack1), .wstb0(wstb0), .wstb1(wstb1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdat0(rdat0), .rdat1(rdat1),
        .done0(done0), .done1(done1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr_en(mem_wr_en),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory attached to the arbiter; preload port is used only while in reset.
    logic [7:0] tb_mem [256];
    logic       pre_we = 0;
    logic [7:0] pre_a = 0, pre_d = 0;
    always @(posedge clk) begin
        if (pre_we) tb_mem[pre_a] <= pre_d;
        else if (mem_wr_en) tb_mem[mem_addr] <= mem_din;
    end
    assign mem_dout = tb_mem[mem_addr];

    typedef struct {
        int           port;
        bit           we;
        int           addr;
        int           len;
        logic [127:0] data;
        bit           first;
        int           issue_cyc;
    } burst_t;

    burst_t     expq[$];
    logic [7:0] ref_mem [256];
    logic [7:0] dq0[$], dq1[$];
    int         ref_last = 1;
    bit         stim_done = 0;
    int         checks = 0, failures = 0;

    task automatic chk(string nm, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, a, e, cyc);
        end
    endtask

    // Expected burst content from the reference memory image.
    task automatic push_burst(int p, bit w, int a, int l, bit first);
        burst_t e;
        logic [7:0] b;
        e.port = p; e.we = w; e.addr = a; e.len = l; e.first = first;
        e.issue_cyc = cyc; e.data = '0;
        for (int k = 0; k <= l; k++) begin
            if (w) begin
                b = 8'($urandom);
                ref_mem[(a + k) % 256] = b;
                if (p == 0) dq0.push_back(b); else dq1.push_back(b);
            end else begin
                b = ref_mem[(a + k) % 256];
            end
            e.data[k*8 +: 8] = b;
        end
        expq.push_back(e);
    endtask

    task automatic issue(bit r0, bit r1, bit w0, int a0, int l0, bit w1, int a1, int l1);
        int n, seen, fp;
        bit s0, s1;
        if (r0 && r1) begin
`ifdef DAT_MEM_ARB_FIXED_PRIO_EN
            fp = 0;
`else
            fp = (ref_last == 0) ? 1 : 0;
`endif
            if (fp == 0) begin
                push_burst(0, w0, a0, l0, 1); push_burst(1, w1, a1, l1, 0); ref_last = 1;
            end else begin
                push_burst(1, w1, a1, l1, 1); push_burst(0, w0, a0, l0, 0); ref_last = 0;
            end
        end else if (r0) begin
            push_burst(0, w0, a0, l0, 1); ref_last = 0;
        end else begin
            push_burst(1, w1, a1, l1, 1); ref_last = 1;
        end
        we0 = w0; addr0 = a0[7:0]; len0 = l0[3:0];
        we1 = w1; addr1 = a1[7:0]; len1 = l1[3:0];
        wdat0 = (dq0.size() > 0) ? dq0[0] : 8'h00;
        wdat1 = (dq1.size() > 0) ? dq1[0] : 8'h00;
        req0 = r0; req1 = r1;
        n = int'(r0) + int'(r1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
            s0 = wstb0; s1 = wstb1;
            seen += int'(done0) + int'(done1);
            if (seen >= n) break;
            @(posedge clk);
            #1;
            if (s0 && dq0.size() > 0) void'(dq0.pop_front());
            if (s1 && dq1.size() > 0) void'(dq1.pop_front());
            wdat0 = (dq0.size() > 0) ? dq0[0] : 8'h00;
            wdat1 = (dq1.size() > 0) ? dq1[0] : 8'h00;
        end
        req0 = 0; req1 = 0;
    endtask

    // Stimulus
    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = (i == 16) ? 8'hAA : (i == 17) ? 8'hBB : (i == 18) ? 8'hCC : 8'($urandom);
            ref_mem[i] = v;
            pre_a = 8'(i); pre_d = v; pre_we = 1;
            @(posedge clk);
            #1;
        end
        pre_we = 0;
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);

        issue(1, 0, 0, 8'h10, 2, 0, 0, 0);
        issue(0, 1, 0, 0, 0, 1, 8'hFE, 2);
        issue(1, 0, 0, 8'hFF, 0, 0, 0, 0);
        issue(1, 0, 0, 8'hFE, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            issue(1, 1, 1'($urandom), $urandom_range(0, 255), 0, 1'($urandom), $urandom_range(0, 255), 0);
        issue(1, 1, 0, $urandom_range(0, 255), 15, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 15));

        // Abandon a read burst with an asynchronous reset.
        push_burst(0, 0, $urandom_range(0, 255), 15, 1);
        we0 = 0; addr0 = expq[expq.size()-1].addr[7:0]; len0 = 4'hF; req0 = 1;
        for (int i = 0; i < 10 && !ack0; i++) @(negedge clk);
        req0 = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        ref_last = 1;
        @(negedge clk);
        issue(1, 1, 0, $urandom_range(0, 255), $urandom_range(0, 15), 1, $urandom_range(0, 255), $urandom_range(0, 15));

        for (int i = 0; i < 40; i++) begin
            int m;
            m = $urandom_range(1, 3);
            issue(m[0], m[1], 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 15),
                  1'($urandom), $urandom_range(0, 255), $urandom_range(0, 15));
        end
        repeat (3) @(negedge clk);
        stim_done = 1;
    end

    // Monitor / scoreboard
    initial begin
        burst_t cur;
        bit act;
        int ack_cyc, last_done, idle, k;
        act = 0; ack_cyc = 0; last_done = 0; idle = 0;
        cur.port = 0; cur.we = 0; cur.len = 0; cur.addr = 0; cur.data = '0;
        while (!stim_done) begin
            @(negedge clk);
            if (!rst_n) begin
                act = 0; idle = 0; expq.delete();
                chk("rst_ack", int'({ack0, ack1}), 0);
                chk("rst_rvalid", int'({rvalid0, rvalid1}), 0);
                chk("rst_done", int'({done0, done1}), 0);
                chk("rst_wstb", int'({wstb0, wstb1}), 0);
                chk("rst_rdat", int'({rdat0, rdat1}), 0);
                chk("rst_mem_addr", int'(mem_addr), 0);
                chk("rst_mem_din", int'(mem_din), 0);
                chk("rst_mem_wr_en", int'(mem_wr_en), 0);
                continue;
            end
            if (ack0 || ack1) begin
                chk("ack_both", int'(ack0 & ack1), 0);
                if (act || expq.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    cur = expq.pop_front();
                    chk("ack_port", int'(ack1), cur.port);
                    chk("ack_cycle", cyc, cur.first ? cur.issue_cyc + 1 : last_done + 1);
                    act = 1; ack_cyc = cyc;
                end
            end
            k = cyc - ack_cyc;
            chk("wstb0", int'(wstb0), int'(act && cur.we && cur.port == 0 && k <= cur.len));
            chk("wstb1", int'(wstb1), int'(act && cur.we && cur.port == 1 && k <= cur.len));
            chk("mem_wr_en", int'(mem_wr_en), int'(act && cur.we && k <= cur.len));
            if (act && k <= cur.len) begin
                chk("mem_addr", int'(mem_addr), (cur.addr + k) % 256);
                if (cur.we) chk("mem_din", int'(mem_din), int'(cur.data[k*8 +: 8]));
            end
            chk("rvalid0", int'(rvalid0), int'(act && !cur.we && cur.port == 0 && k >= 1 && k <= cur.len + 1));
            chk("rvalid1", int'(rvalid1), int'(act && !cur.we && cur.port == 1 && k >= 1 && k <= cur.len + 1));
            if (act && !cur.we && k >= 1 && k <= cur.len + 1)
                chk("rdat", int'(cur.port == 0 ? rdat0 : rdat1), int'(cur.data[(k-1)*8 +: 8]));
            chk("done0", int'(done0), int'(act && cur.port == 0 && k == cur.len + 1));
            chk("done1", int'(done1), int'(act && cur.port == 1 && k == cur.len + 1));
            if (act && k >= cur.len + 1) begin
                act = 0; last_done = cyc;
            end
            if (act || expq.size() > 0) idle++; else idle = 0;
            if (idle > 60) begin
                chk("progress_timeout", idle, 0);
                expq.delete(); act = 0; idle = 0;
            end
        end
        chk("queue_empty", expq.size(), 0);
        chk("burst_open", int'(act), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/dat_mem_arbiter.md
Name: dat_mem_arbiter

Overview:
- Two-requester burst arbiter and sequencer for the 256x8 single-port data memory (combinational read, clocked write).
- Grants one requester at a time and runs a burst of 1..2^LW consecutive byte reads or writes, driving the memory's addr/dat_in/wr_en.
- Returns registered read data and done strobes.
- Sits between the core load/store path (port 0) and a DMA/copy engine (port 1) and the memory.

Parameters:
- AW, 8, address width; memory depth 2^AW, addresses wrap modulo 2^AW.
- DW, 8, data width.
- LW, 4, burst length field width; beats = len+1 (1..16).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request, level; sampled only in IDLE.
- we0 / we1  in  1  1=write burst, 0=read burst; sampled with req.
- addr0 / addr1  in  AW  burst start address.
- len0 / len1  in  LW  beats minus one.
- wdat0 / wdat1  in  DW  write data for the current beat.
- ack0 / ack1  out  1  one-cycle pulse: request captured.
- wstb0 / wstb1  out  1  combinational: wdatX consumed at this clock edge.
- rvalid0 / rvalid1  out  1  registered: rdatX holds a read beat.
- rdat0 / rdat1  out  DW  registered read data, shared value.
- done0 / done1  out  1  one-cycle pulse: burst complete.
- mem_addr  out  AW  to memory addr.
- mem_din  out  DW  to memory dat_in.
- mem_wr_en  out  1  to memory wr_en.
- mem_dout  in  DW  from memory dat_out.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; last-served pointer=1, so port 0 wins the first tie.
  - All ack/rvalid/done=0; rdat=0; mem_addr=0; mem_wr_en=0; mem_din=0.
- States: IDLE, BUSY.
- IDLE:
  - mem_wr_en=0.
  - If any req: choose owner by round robin, where the port not served last wins a tie.
  - Latch we, addr, len into cur_we, cur_addr, cnt.
  - Next state BUSY; ackOwner=1 in the first BUSY cycle.
  - No req: stay in IDLE.
- BUSY, every cycle is one beat:
  - mem_addr=cur_addr.
  - mem_wr_en=cur_we.
  - mem_din=wdatOwner (combinational mux).
  - wstbOwner=cur_we (combinational).
  - For reads: rdatOwner<=mem_dout and rvalidOwner<=1 at the edge; read data is visible one cycle after its address.
  - cur_addr<=cur_addr+1 modulo 2^AW (0xFF -> 0x00); cnt<=cnt-1.
- Last beat (cnt==0):
  - Next state IDLE.
  - doneOwner<=1, in the same cycle as the last rvalid for reads.
  - last-served<=owner.
- Latency:
  - Burst of N beats occupies N BUSY cycles plus 1 IDLE cycle.
  - Minimum request-to-request turnaround is N+1 cycles.
- Request handling:
  - Requester must drop req on the cycle ack is seen.
  - req still high on return to IDLE is a new burst.
  - req changes during BUSY are ignored; the non-owner's req is held off with no ack.
- Simultaneous req0 and req1 in IDLE: round robin alternates (0,1,0,1...) while both stay asserted.
- Outputs to the non-owner port: wstb/rvalid/done/ack = 0.
- Reset mid-burst: burst abandoned, no done, partial writes remain in memory.

Optional Feature:
- Macro: DAT_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins ties, and the last-served pointer is removed.
- Undefined: round robin as above.

Test Plan:
- Reset: hold rst_n=0 mid-operation -> all outputs 0, mem_wr_en=0 within the same cycle (async); first tie after release goes to port 0.
- Read burst: memory preloaded 0x10..0x12 = AA,BB,CC; req0, we0=0, addr0=0x10, len0=2 -> ack0 in cycle 1; mem_addr 10,11,12 in cycles 1-3; rvalid0 with AA,BB,CC in cycles 2-4; done0 in cycle 4.
- Write wrap: req1, we1=1, addr1=0xFE, len1=2, wdat1 advanced on each wstb1 (11,22,33) -> memory FE=11, FF=22, 00=33; mem_wr_en high exactly 3 cycles; done1 once.
- Contention: req0 and req1 held high for 4 bursts of len=0 -> grant order 0,1,0,1, each burst 2 cycles apart; with DAT_MEM_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- Hold-off: req1 asserted during port 0's 16-beat burst -> no ack1 until port 0's done0; ack1 on the following BUSY entry.
- Single-beat read at 0xFF (len=0) -> rvalid and done on the same cycle; cur_addr wraps to 0 without side effects.
